// File: rtl/axi_mem_pkg.sv
// Shared encodings for the AXI3 slave memory model: burst types, responses, FSM states.
package axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address, active byte lanes and burst legality check.
// WRAP bursts are only legal when AXI_MEM_WRAP_EN is defined.
module axi_burst_addr
    import axi_mem_pkg::*;
#(
    parameter int ADDR_LENGTH = 12,
    parameter int WIDTH_DS    = 4
) (
    input  logic [ADDR_LENGTH-1:0] addr,
    input  logic [3:0]             len,
    input  logic [2:0]             size,
    input  logic [1:0]             burst,
    output logic [ADDR_LENGTH-1:0] next_addr,
    output logic [WIDTH_DS-1:0]    lane_mask,
    output logic                   err
);
    localparam int LB = $clog2(WIDTH_DS);

    logic [ADDR_LENGTH-1:0] step;
    logic [ADDR_LENGTH-1:0] size_mask;
`ifdef AXI_MEM_WRAP_EN
    logic [ADDR_LENGTH-1:0] wrap_mask;
    logic                   wrap_ok;
`endif

    always_comb begin
        step      = ADDR_LENGTH'(1) << size;
        size_mask = step - ADDR_LENGTH'(1);
        next_addr = addr;
        err       = (size > 3'(LB));
`ifdef AXI_MEM_WRAP_EN
        wrap_mask = ((ADDR_LENGTH'(len) + ADDR_LENGTH'(1)) << size) - ADDR_LENGTH'(1);
        wrap_ok   = ((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15))
                    && ((addr & size_mask) == '0);
`endif
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = (addr & ~size_mask) + step;
`ifdef AXI_MEM_WRAP_EN
            BURST_WRAP: begin
                next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
                err       = err | !wrap_ok;
            end
`endif
            default:     err = 1'b1;
        endcase
        // A lane is inside the transfer window when its index matches the address above bit 'size'.
        lane_mask = '0;
        for (int i = 0; i < WIDTH_DS; i++) begin
            lane_mask[i] = ((LB'(i) >> size) == (addr[LB-1:0] >> size));
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI3 slave memory model with independent write and read engines over a byte array.
// Define AXI_MEM_WRAP_EN to support WRAP bursts; otherwise WRAP is treated as reserved.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int WIDTH_ID    = 4,
    parameter int WIDTH_AD    = 32,
    parameter int WIDTH_DA    = 32,
    parameter int WIDTH_DS    = WIDTH_DA / 8,
    parameter int ADDR_LENGTH = 12
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [WIDTH_ID-1:0] AWID,
    input  logic [WIDTH_AD-1:0] AWADDR,
    input  logic [3:0]          AWLEN,
    input  logic [1:0]          AWLOCK,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [WIDTH_ID-1:0] WID,
    input  logic [WIDTH_DA-1:0] WDATA,
    input  logic [WIDTH_DS-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [WIDTH_ID-1:0] BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [WIDTH_ID-1:0] ARID,
    input  logic [WIDTH_AD-1:0] ARADDR,
    input  logic [3:0]          ARLEN,
    input  logic [1:0]          ARLOCK,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [WIDTH_ID-1:0] RID,
    output logic [WIDTH_DA-1:0] RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);
    localparam int AL = ADDR_LENGTH;
    localparam int LB = $clog2(WIDTH_DS);

    logic [7:0] mem [0:(1<<AL)-1];

    logic [1:0]          w_state_q, w_state_d;
    logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [WIDTH_ID-1:0] bid_q, bid_d, wid_q, wid_d;
    logic [1:0]          bresp_q, bresp_d, wburst_q, wburst_d;
    logic [AL-1:0]       waddr_q, waddr_d, w_next;
    logic [3:0]          wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]          wsize_q, wsize_d;
    logic                werr_q, werr_d, w_aerr, w_last_cnt, w_beat_err;
    logic [WIDTH_DS-1:0] w_lanes, mem_we;

    logic [0:0]          r_state_q, r_state_d;
    logic                arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [WIDTH_ID-1:0] rid_q, rid_d;
    logic [WIDTH_DA-1:0] rdata_q, rdata_d, rword;
    logic [1:0]          rresp_q, rresp_d, rburst_q, rburst_d, ra_burst;
    logic [AL-1:0]       raddr_q, raddr_d, ra_addr, r_next;
    logic [3:0]          rlen_q, rlen_d, rcnt_q, rcnt_d, ra_len;
    logic [2:0]          rsize_q, rsize_d, ra_size;
    logic                r_aerr, r_idle;
    logic [AL-LB-1:0]    rd_base;
    logic [WIDTH_DS-1:0] r_lanes_unused;
    logic                unused_ok;

    assign unused_ok = ^{AWLOCK, ARLOCK, AWADDR[WIDTH_AD-1:AL], ARADDR[WIDTH_AD-1:AL], r_lanes_unused};

    axi_burst_addr #(.ADDR_LENGTH(AL), .WIDTH_DS(WIDTH_DS)) u_waddr (
        .addr(waddr_q), .len(wlen_q), .size(wsize_q), .burst(wburst_q),
        .next_addr(w_next), .lane_mask(w_lanes), .err(w_aerr)
    );

    // The read engine checks the incoming AR fields while idle so beat 0 can launch on the handshake.
    assign r_idle   = (r_state_q == R_IDLE);
    assign ra_addr  = r_idle ? ARADDR[AL-1:0] : raddr_q;
    assign ra_len   = r_idle ? ARLEN   : rlen_q;
    assign ra_size  = r_idle ? ARSIZE  : rsize_q;
    assign ra_burst = r_idle ? ARBURST : rburst_q;

    axi_burst_addr #(.ADDR_LENGTH(AL), .WIDTH_DS(WIDTH_DS)) u_raddr (
        .addr(ra_addr), .len(ra_len), .size(ra_size), .burst(ra_burst),
        .next_addr(r_next), .lane_mask(r_lanes_unused), .err(r_aerr)
    );

    always_comb begin
        mem_we = '0;
        if (w_state_q == W_DATA && WVALID && wready_q && !w_aerr) mem_we = WSTRB & w_lanes;
    end

    always_ff @(posedge ACLK) begin
        for (int i = 0; i < WIDTH_DS; i++) begin
            if (mem_we[i]) mem[{waddr_q[AL-1:LB], LB'(i)}] <= WDATA[8*i +: 8];
        end
    end

    // Nonblocking memory update gives read-before-write on same-cycle collisions.
    always_comb begin
        rd_base = r_idle ? ARADDR[AL-1:LB] : r_next[AL-1:LB];
        rword   = '0;
        for (int i = 0; i < WIDTH_DS; i++) begin
            rword[8*i +: 8] = mem[{rd_base, LB'(i)}];
        end
    end

    always_comb begin
        w_state_d  = w_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        wid_d      = wid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wsize_d    = wsize_q;
        wburst_d   = wburst_q;
        wcnt_d     = wcnt_q;
        werr_d     = werr_q;
        w_last_cnt = (wcnt_q == wlen_q);
        w_beat_err = (WLAST != w_last_cnt) || (WID != wid_q);
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (AWVALID && awready_q) begin
                    wid_d     = AWID;
                    waddr_d   = AWADDR[AL-1:0];
                    wlen_d    = AWLEN;
                    wsize_d   = AWSIZE;
                    wburst_d  = AWBURST;
                    wcnt_d    = '0;
                    werr_d    = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID && wready_q) begin
                    werr_d = werr_q | w_beat_err | w_aerr;
                    // An early WLAST closes the burst here, flagged by w_beat_err.
                    if (w_last_cnt || WLAST) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = wid_q;
                        bresp_d   = (werr_q | w_beat_err | w_aerr) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        waddr_d = w_next;
                        wcnt_d  = wcnt_q + 4'd1;
                    end
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    rid_d     = ARID;
                    raddr_d   = ARADDR[AL-1:0];
                    rlen_d    = ARLEN;
                    rsize_d   = ARSIZE;
                    rburst_d  = ARBURST;
                    rcnt_d    = '0;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (ARLEN == 4'd0);
                    rresp_d   = r_aerr ? RESP_SLVERR : RESP_OKAY;
                    rdata_d   = r_aerr ? '0 : rword;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d = r_next;
                        rcnt_d  = rcnt_q + 4'd1;
                        rlast_d = ((rcnt_q + 4'd1) == rlen_q);
                        rdata_d = (rresp_q == RESP_SLVERR) ? '0 : rword;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: vector table of single transfers plus burst/reset sequences.
module tb_axi_mem_slave;
    import axi_mem_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  AWID, WID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [3:0]  AWLEN, ARLEN, WSTRB;
    logic [1:0]  AWLOCK, AWBURST, ARLOCK, ARBURST, BRESP, RRESP;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    always #5 ACLK = ~ACLK;

    axi_mem_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWLOCK(AWLOCK), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARLOCK(ARLOCK), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] id);
        int t = 0;
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = a; AWLEN = l; AWSIZE = s; AWBURST = b; AWID = id; AWLOCK = 2'b00;
        while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
        chk("aw_handshake_timeout", 64'(t < 50), 64'd1);
        @(posedge ACLK);
        #1 AWVALID = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] id);
        int t = 0;
        @(negedge ACLK);
        ARVALID = 1'b1; ARADDR = a; ARLEN = l; ARSIZE = s; ARBURST = b; ARID = id; ARLOCK = 2'b01;
        while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
        chk("ar_handshake_timeout", 64'(t < 50), 64'd1);
        @(posedge ACLK);
        #1 ARVALID = 1'b0;
    endtask

    // Beat i carries d+i; WLAST is raised on beat last_at, which may be earlier than l.
    task automatic axi_wr(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [3:0] id, input logic [3:0] wid,
                          input logic [31:0] d, input logic [3:0] st, input int last_at,
                          output logic [1:0] resp, output logic [3:0] bid);
        int t;
        aw_send(a, l, s, b, id);
        for (int i = 0; i <= last_at; i++) begin
            @(negedge ACLK);
            WVALID = 1'b1; WID = wid; WDATA = d + 32'(i); WSTRB = st; WLAST = (i == last_at);
            t = 0;
            while (!WREADY && t < 50) begin @(negedge ACLK); t++; end
            chk("w_ready_timeout", 64'(t < 50), 64'd1);
            @(posedge ACLK);
        end
        @(negedge ACLK);
        WVALID = 1'b0; WLAST = 1'b0;
        t = 0;
        while (!BVALID && t < 50) begin @(negedge ACLK); t++; end
        chk("b_valid_timeout", 64'(t < 50), 64'd1);
        resp = BRESP;
        bid  = BID;
        @(posedge ACLK);
        #1;
    endtask

    // Each beat must be valid at the first negedge after the previous edge (latency 1, no bubbles).
    task automatic axi_rd(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [3:0] id, input logic [31:0] ex [16],
                          input logic [1:0] er, input int stall, input string nm);
        int t;
        RREADY = (stall == 0);
        ar_send(a, l, s, b, id);
        for (int i = 0; i <= int'(l); i++) begin
            @(negedge ACLK);
            t = 0;
            while (!RVALID && t < 50) begin @(negedge ACLK); t++; end
            chk({nm, "_rvalid_wait"}, 64'(t), 64'd0);
            for (int k = 0; k < stall; k++) begin
                RREADY = 1'b0;
                chk({nm, "_stall_rdata"}, 64'(RDATA), 64'(ex[i]));
                chk({nm, "_stall_rlast"}, 64'(RLAST), 64'(i == int'(l)));
                @(negedge ACLK);
            end
            RREADY = 1'b1;
            chk({nm, "_rvalid"}, 64'(RVALID), 64'd1);
            chk({nm, "_rdata"}, 64'(RDATA), 64'(ex[i]));
            chk({nm, "_rlast"}, 64'(RLAST), 64'(i == int'(l)));
            chk({nm, "_rresp"}, 64'(RRESP), 64'(er));
            chk({nm, "_rid"}, 64'(RID), 64'(id));
            @(posedge ACLK);
        end
        @(negedge ACLK);
        chk({nm, "_rvalid_done"}, 64'(RVALID), 64'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        string       name;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [3:0]  bid;
        logic [31:0] ex [16];

        vt[0]  = '{1'b1, 32'h30,   4'd0, 3'd2, BURST_INCR,  4'd3, 32'hDEADBEEF, 4'hF,    RESP_OKAY,   32'h0,        "wr_single"};
        vt[1]  = '{1'b0, 32'h30,   4'd0, 3'd2, BURST_INCR,  4'd5, 32'h0,        4'h0,    RESP_OKAY,   32'hDEADBEEF, "rd_single"};
        vt[2]  = '{1'b1, 32'h50,   4'd0, 3'd2, BURST_INCR,  4'd1, 32'hAABBCCDD, 4'hF,    RESP_OKAY,   32'h0,        "wr_strb_full"};
        vt[3]  = '{1'b1, 32'h50,   4'd0, 3'd2, BURST_INCR,  4'd1, 32'h11223344, 4'b0101, RESP_OKAY,   32'h0,        "wr_strb_part"};
        vt[4]  = '{1'b0, 32'h50,   4'd0, 3'd2, BURST_INCR,  4'd2, 32'h0,        4'h0,    RESP_OKAY,   32'hAA22CC44, "rd_strb"};
        vt[5]  = '{1'b1, 32'h70,   4'd0, 3'd2, BURST_INCR,  4'd4, 32'hCAFEF00D, 4'hF,    RESP_OKAY,   32'h0,        "wr_pre_rsvd"};
        vt[6]  = '{1'b1, 32'h70,   4'd0, 3'd2, 2'b11,       4'd4, 32'h55555555, 4'hF,    RESP_SLVERR, 32'h0,        "wr_rsvd"};
        vt[7]  = '{1'b0, 32'h70,   4'd0, 3'd2, BURST_INCR,  4'd4, 32'h0,        4'h0,    RESP_OKAY,   32'hCAFEF00D, "rd_after_rsvd"};
        vt[8]  = '{1'b0, 32'h70,   4'd0, 3'd2, 2'b11,       4'd6, 32'h0,        4'h0,    RESP_SLVERR, 32'h0,        "rd_rsvd"};
        vt[9]  = '{1'b1, 32'h80,   4'd0, 3'd2, BURST_INCR,  4'd0, 32'h01020304, 4'hF,    RESP_OKAY,   32'h0,        "wr_word80"};
        vt[10] = '{1'b1, 32'h81,   4'd0, 3'd0, BURST_INCR,  4'd0, 32'h9999EE99, 4'hF,    RESP_OKAY,   32'h0,        "wr_byte81"};
        vt[11] = '{1'b0, 32'h80,   4'd0, 3'd2, BURST_INCR,  4'd0, 32'h0,        4'h0,    RESP_OKAY,   32'h0102EE04, "rd_size_window"};
        vt[12] = '{1'b1, 32'h1090, 4'd0, 3'd2, BURST_INCR,  4'd8, 32'h00000077, 4'hF,    RESP_OKAY,   32'h0,        "wr_alias"};
        vt[13] = '{1'b0, 32'h090,  4'd0, 3'd2, BURST_INCR,  4'd8, 32'h0,        4'h0,    RESP_OKAY,   32'h00000077, "rd_alias"};
        vt[14] = '{1'b1, 32'hFFC,  4'd1, 3'd2, BURST_INCR,  4'd9, 32'h00000200, 4'hF,    RESP_OKAY,   32'h0,        "wr_top_wrap"};
        vt[15] = '{1'b0, 32'h000,  4'd0, 3'd2, BURST_INCR,  4'd9, 32'h0,        4'h0,    RESP_OKAY,   32'h00000201, "rd_top_wrap"};
        vt[16] = '{1'b1, 32'hA0,   4'd1, 3'd2, BURST_FIXED, 4'hA, 32'h00000100, 4'hF,    RESP_OKAY,   32'h0,        "wr_fixed"};
        vt[17] = '{1'b0, 32'hA0,   4'd0, 3'd2, BURST_INCR,  4'hA, 32'h0,        4'h0,    RESP_OKAY,   32'h00000101, "rd_fixed"};

        AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWLOCK = 0; AWSIZE = 0; AWBURST = 0;
        WVALID = 0; WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 1;
        ARVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARLOCK = 0; ARSIZE = 0; ARBURST = 0; RREADY = 1;
        for (int i = 0; i < 16; i++) ex[i] = 32'h0;

        repeat (3) @(negedge ACLK);
        chk("rst_awready", 64'(AWREADY), 64'd0);
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_wready", 64'(WREADY), 64'd0);
        chk("rst_bvalid", 64'(BVALID), 64'd0);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_rlast", 64'(RLAST), 64'd0);
        chk("rst_rdata", 64'(RDATA), 64'd0);
        ARESETn = 1'b1;
        #1 chk("rst_awready_before_edge", 64'(AWREADY), 64'd0);
        @(posedge ACLK);
        #1;
        chk("rst_awready_first_edge", 64'(AWREADY), 64'd1);
        chk("rst_arready_first_edge", 64'(ARREADY), 64'd1);

        for (int k = 0; k < NV; k++) begin
            if (vt[k].wr) begin
                axi_wr(vt[k].addr, vt[k].len, vt[k].size, vt[k].burst, vt[k].id, vt[k].id,
                       vt[k].data, vt[k].strb, int'(vt[k].len), resp, bid);
                chk({vt[k].name, "_bresp"}, 64'(resp), 64'(vt[k].resp));
                chk({vt[k].name, "_bid"}, 64'(bid), 64'(vt[k].id));
            end else begin
                for (int i = 0; i < 16; i++) ex[i] = vt[k].rdata + 32'(i);
                axi_rd(vt[k].addr, vt[k].len, vt[k].size, vt[k].burst, vt[k].id, ex,
                       vt[k].resp, 0, vt[k].name);
            end
        end

        // Two back-to-back INCR bursts read back as one 8-beat stream.
        axi_wr(32'h30, 4'd3, 3'd2, BURST_INCR, 4'd7, 4'd7, 32'h1000, 4'hF, 3, resp, bid);
        chk("incr_a_bresp", 64'(resp), 64'(RESP_OKAY));
        chk("incr_a_bid", 64'(bid), 64'd7);
        axi_wr(32'h40, 4'd3, 3'd2, BURST_INCR, 4'd7, 4'd7, 32'h1000, 4'hF, 3, resp, bid);
        chk("incr_b_bresp", 64'(resp), 64'(RESP_OKAY));
        for (int i = 0; i < 8; i++) ex[i] = 32'h1000 + 32'(i % 4);
        axi_rd(32'h30, 4'd7, 3'd2, BURST_INCR, 4'd9, ex, RESP_OKAY, 0, "rd_incr8");

        for (int i = 0; i < 4; i++) ex[i] = 32'h1000 + 32'(i);
        axi_rd(32'h30, 4'd3, 3'd2, BURST_INCR, 4'd3, ex, RESP_OKAY, 3, "rd_backpressure");

        axi_wr(32'h38, 4'd3, 3'd2, BURST_WRAP, 4'd1, 4'd1, 32'h3000, 4'hF, 3, resp, bid);
`ifdef AXI_MEM_WRAP_EN
        chk("wrap_bresp", 64'(resp), 64'(RESP_OKAY));
        ex[0] = 32'h3002; ex[1] = 32'h3003; ex[2] = 32'h3000; ex[3] = 32'h3001;
`else
        chk("wrap_bresp", 64'(resp), 64'(RESP_SLVERR));
        for (int i = 0; i < 4; i++) ex[i] = 32'h1000 + 32'(i);
`endif
        axi_rd(32'h30, 4'd3, 3'd2, BURST_INCR, 4'd1, ex, RESP_OKAY, 0, "rd_wrap_check");

        axi_wr(32'hC0, 4'd3, 3'd2, BURST_INCR, 4'd4, 4'd4, 32'h4000, 4'hF, 1, resp, bid);
        chk("early_wlast_bresp", 64'(resp), 64'(RESP_SLVERR));
        chk("early_wlast_bid", 64'(bid), 64'd4);
        ex[0] = 32'h4000; ex[1] = 32'h4001;
        axi_rd(32'hC0, 4'd1, 3'd2, BURST_INCR, 4'd4, ex, RESP_OKAY, 0, "rd_early_wlast");

        axi_wr(32'hD0, 4'd0, 3'd2, BURST_INCR, 4'd2, 4'd3, 32'h5000, 4'hF, 0, resp, bid);
        chk("wid_mismatch_bresp", 64'(resp), 64'(RESP_SLVERR));
        chk("wid_mismatch_bid", 64'(bid), 64'd2);

        // Asynchronous reset in the middle of a read burst.
        RREADY = 1'b1;
        ar_send(32'h40, 4'd7, 3'd2, BURST_INCR, 4'd6);
        @(negedge ACLK);
        @(negedge ACLK);
        chk("rst_mid_rvalid_before", 64'(RVALID), 64'd1);
        #2 ARESETn = 1'b0;
        #1;
        chk("rst_mid_rvalid", 64'(RVALID), 64'd0);
        chk("rst_mid_arready", 64'(ARREADY), 64'd0);
        chk("rst_mid_rlast", 64'(RLAST), 64'd0);
        chk("rst_mid_rdata", 64'(RDATA), 64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1 chk("rst_rel_arready_before_edge", 64'(ARREADY), 64'd0);
        @(posedge ACLK);
        #1;
        chk("rst_rel_arready", 64'(ARREADY), 64'd1);
        chk("rst_rel_rvalid", 64'(RVALID), 64'd0);
        ex[0] = 32'h1000;
        axi_rd(32'h40, 4'd0, 3'd2, BURST_INCR, 4'd6, ex, RESP_OKAY, 0, "rd_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
